// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the switch input conditioning stage.
// The default debounce window is 5 ms of the 10 MHz system clock.
package switch_debouncer_pkg;

    localparam int unsigned SW_W = 8;
    localparam int unsigned SYS_CLK_HZ = 10_000_000;
    localparam int unsigned DEBOUNCE_MS = 5;
    localparam logic [15:0] DEFAULT_DEBOUNCE_CYCLES = 16'(SYS_CLK_HZ / 1000 * DEBOUNCE_MS);

    typedef logic [SW_W-1:0] sw_word_t;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch word bundle: raw pins in, debounced word, edge strobes and status out.
interface switch_debouncer_if;
    import switch_debouncer_pkg::*;

    sw_word_t sw_raw;
    sw_word_t sw_stable;
    sw_word_t sw_rise;
    sw_word_t sw_fall;
    logic     sw_changed;
    logic     settled;

    modport master (
        output sw_raw,
        input  sw_stable, sw_rise, sw_fall, sw_changed, settled
    );

    modport slave (
        input  sw_raw,
        output sw_stable, sw_rise, sw_fall, sw_changed, settled
    );
endinterface

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: 2-flop synchroniser, consecutive-cycle counter, stable flop
// and registered rise/fall strobes aligned with the stable update.
module debounce_bit #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
    parameter int unsigned CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic mismatch
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

    logic             s1_reg;
    logic             s2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             stable_reg;
    logic             rise_reg;
    logic             fall_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            s1_reg   <= raw;
            s2_reg   <= s1_reg;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            // Any revert to the stable level discards the partial count.
            if (s2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_LAST) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else begin
                stable_reg <= s2_reg;
                cnt_reg    <= '0;
                rise_reg   <= s2_reg;
                fall_reg   <= ~s2_reg;
            end
        end
    end

    assign stable   = stable_reg;
    assign rise     = rise_reg;
    assign fall     = fall_reg;
    assign mismatch = s2_reg ^ stable_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the 8 switch pins so the compare-value mux sees a clean word;
// also reports per-bit edge strobes and an all-bits-settled flag.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    switch_debouncer_if.slave sw
);

    sw_word_t stable_bits;
    sw_word_t rise_bits;
    sw_word_t fall_bits;
    sw_word_t mismatch_bits;

    generate
        for (genvar gi = 0; gi < SW_W; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_bit (
                .clk      (clk),
                .reset    (reset),
                .raw      (sw.sw_raw[gi]),
                .stable   (stable_bits[gi]),
                .rise     (rise_bits[gi]),
                .fall     (fall_bits[gi]),
                .mismatch (mismatch_bits[gi])
            );
        end
    endgenerate

    assign sw.sw_stable  = stable_bits;
    assign sw.sw_rise    = rise_bits;
    assign sw.sw_fall    = fall_bits;
    assign sw.sw_changed = |(rise_bits | fall_bits);
    assign sw.settled    = ~|mismatch_bits;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench: N=4 instance for the main cases, N=1 instance for the
// single-cycle-window case. Expected values are hand-derived edge by edge.
module tb_switch_debouncer;
    import switch_debouncer_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    switch_debouncer_if sw4 ();
    switch_debouncer_if sw1 ();

    switch_debouncer #(.DEBOUNCE_CYCLES(16'd4), .CNT_W(16)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .sw    (sw4.slave)
    );

    switch_debouncer #(.DEBOUNCE_CYCLES(16'd1), .CNT_W(16)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .sw    (sw1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("check %s ok value %h", tag, got);
        end
    endtask

    // {stable, rise, fall, changed, settled}
    function automatic logic [31:0] obs4();
        return {6'd0, sw4.sw_stable, sw4.sw_rise, sw4.sw_fall, sw4.sw_changed, sw4.settled};
    endfunction

    function automatic logic [31:0] obs1();
        return {6'd0, sw1.sw_stable, sw1.sw_rise, sw1.sw_fall, sw1.sw_changed, sw1.settled};
    endfunction

    function automatic logic [31:0] pack_exp(input sw_word_t st, input sw_word_t ri,
                                             input sw_word_t fa, input logic ch, input logic se);
        return {6'd0, st, ri, fa, ch, se};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply a held level and follow edges 0..7; acceptance is at edge 5 for N=4.
    task automatic run_transition(input string tag, input sw_word_t from_w, input sw_word_t to_w);
        sw_word_t st;
        sw_word_t ri;
        sw_word_t fa;
        logic     ch;
        logic     se;
        sw4.sw_raw = to_w;
        for (int e = 0; e < 8; e++) begin
            step();
            st = (e >= 5) ? to_w : from_w;
            ri = (e == 5) ? (to_w & ~from_w) : 8'h00;
            fa = (e == 5) ? (from_w & ~to_w) : 8'h00;
            ch = (e == 5) && (from_w != to_w);
            se = !((e >= 1) && (e <= 4) && (from_w != to_w));
            check($sformatf("%s_e%0d", tag, e), obs4(), pack_exp(st, ri, fa, ch, se));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        sw4.sw_raw = 8'h00;
        sw1.sw_raw = 8'h00;
        repeat (3) step();
        check("reset_state", obs4(), pack_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
        reset = 1'b0;

        // Idle with all switches low.
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("idle_c%0d", c), obs4(), pack_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
        end

        run_transition("rise_b0", 8'h00, 8'h01);

        // Bit 3 bounce: high 3, low 1, then high held; final high sampled at edge 4.
        for (int c = 0; c < 12; c++) begin
            sw4.sw_raw = (c == 3) ? 8'h01 : 8'h09;
            step();
            check($sformatf("bounce_b3_e%0d", c), {8'd0, sw4.sw_stable, sw4.sw_rise, sw4.sw_fall},
                  {8'd0, (c >= 9) ? 8'h09 : 8'h01, (c == 9) ? 8'h08 : 8'h00, 8'h00});
        end

        run_transition("fall_09", 8'h09, 8'h00);
        run_transition("rise_a5", 8'h00, 8'hA5);
        run_transition("fall_a5", 8'hA5, 8'h00);

        // Reset two cycles into counting on bit 0 discards the count.
        sw4.sw_raw = 8'h01;
        for (int e = 0; e < 4; e++) begin
            step();
            check($sformatf("pre_reset_e%0d", e), {24'd0, sw4.sw_stable}, 32'h0);
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check($sformatf("in_reset_c%0d", c), obs4(), pack_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
        end
        reset = 1'b0;
        run_transition("post_reset", 8'h00, 8'h01);

        // N=1: single-cycle pulse on bit 7 toggles stable at edges 2 and 3.
        sw1.sw_raw = 8'h80;
        for (int e = 0; e < 5; e++) begin
            step();
            sw1.sw_raw = 8'h00;
            case (e)
                2:       check("n1_e2", obs1(), pack_exp(8'h80, 8'h80, 8'h00, 1'b1, 1'b0));
                3:       check("n1_e3", obs1(), pack_exp(8'h00, 8'h00, 8'h80, 1'b1, 1'b1));
                1:       check("n1_e1", obs1(), pack_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
                default: check($sformatf("n1_e%0d", e), obs1(), pack_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
